rssb_ctrl_fsm: RTL and testbench



---
 rtl/rssb_ctrl_fsm.sv | 124 ++++++++++++
 tb/tb_rssb_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rssb_ctrl_fsm.sv
// Control sequencer for the RSSB single-instruction processor: a Moore FSM driving datapath enables/selects.
// Optional single-step pause after each instruction is enabled by defining RSSB_STEP_EN.
module rssb_ctrl_fsm #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] HALT_ADDR = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             neg,
  input  logic [WIDTH-1:0] instr_data,
  input  logic             step,
  output logic             write_pc,
  output logic             sel_pc,
  output logic             write_op1,
  output logic             write_acc,
  output logic             write_mem,
  output logic             sel_mem,
  output logic             busy,
  output logic             halted,
  output logic [WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_PCUPD  = 3'd5,
    S_HALT   = 3'd6,
    S_PAUSE  = 3'd7
  } state_t;

  state_t           state_reg, state_next;
  logic             neg_q_reg;
  logic [WIDTH-1:0] retired_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      neg_q_reg   <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Borrow is only meaningful while the subtractor result is being written back.
      if (state_reg == S_EXEC)
        neg_q_reg <= neg;
      if (state_reg == S_PCUPD)
        retired_reg <= retired_reg + 1'b1;
    end
  end

`ifndef RSSB_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  always_comb begin
    state_next = state_reg;
    write_pc   = 1'b0;
    sel_pc     = 1'b0;
    write_op1  = 1'b0;
    write_acc  = 1'b0;
    write_mem  = 1'b0;
    sel_mem    = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start)
          state_next = S_FETCH;
      end
      S_FETCH: begin
        busy       = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        busy       = 1'b1;
        write_op1  = 1'b1;
        // op1 is latched even for the halt operand.
        state_next = (instr_data == HALT_ADDR) ? S_HALT : S_READ;
      end
      S_READ: begin
        busy       = 1'b1;
        sel_mem    = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        busy       = 1'b1;
        sel_mem    = 1'b1;
        write_mem  = 1'b1;
        write_acc  = 1'b1;
        state_next = S_PCUPD;
      end
      S_PCUPD: begin
        busy       = 1'b1;
        write_pc   = 1'b1;
        sel_pc     = neg_q_reg;
`ifdef RSSB_STEP_EN
        state_next = S_PAUSE;
`else
        state_next = S_FETCH;
`endif
      end
      S_HALT: begin
        halted = 1'b1;
      end
`ifdef RSSB_STEP_EN
      S_PAUSE: begin
        busy = 1'b1;
        if (step)
          state_next = S_FETCH;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign retired = retired_reg;

endmodule

// File: tb/tb_rssb_ctrl_fsm.sv
// Self-checking bench for rssb_ctrl_fsm: directed vector table, corner-case sequences, and
// randomized stimulus against an instruction-phase reference model.
module tb_rssb_ctrl_fsm;
  localparam int W = 8;

  // Output pattern order: {write_pc, sel_pc, write_op1, write_acc, write_mem, sel_mem, busy, halted}
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_FETCH = 8'b0000_0010;
  localparam logic [7:0] O_DEC   = 8'b0010_0010;
  localparam logic [7:0] O_READ  = 8'b0000_0110;
  localparam logic [7:0] O_EXEC  = 8'b0001_1110;
  localparam logic [7:0] O_PC0   = 8'b1000_0010;
  localparam logic [7:0] O_PC1   = 8'b1100_0010;
  localparam logic [7:0] O_HALT  = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst, start, neg, step;
  logic [W-1:0] instr_data;
  logic write_pc, sel_pc, write_op1, write_acc, write_mem, sel_mem, busy, halted;
  logic [W-1:0] retired;

  always #5 clk = ~clk;

  rssb_ctrl_fsm #(.WIDTH(W), .HALT_ADDR(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .neg(neg), .instr_data(instr_data), .step(step),
    .write_pc(write_pc), .sel_pc(sel_pc), .write_op1(write_op1), .write_acc(write_acc),
    .write_mem(write_mem), .sel_mem(sel_mem), .busy(busy), .halted(halted), .retired(retired)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [7:0] douts();
    return {write_pc, sel_pc, write_op1, write_acc, write_mem, sel_mem, busy, halted};
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_cycle(input string name, input logic [7:0] exp_o, input logic [W-1:0] exp_r);
    n_checks++;
    if (douts() === exp_o && retired === exp_r) n_pass++;
    else $display("FAIL %s: outs=%b retired=%0d, expected outs=%b retired=%0d",
                  name, douts(), retired, exp_o, exp_r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic n, input logic [W-1:0] d, input logic st);
    rst = r; start = s; neg = n; instr_data = d; step = st;
  endtask

  // Directed vectors: inputs for a cycle and the outputs expected in that same cycle.
  typedef struct {
    logic           rst;
    logic           start;
    logic           neg;
    logic [W-1:0]   instr;
    logic [7:0]     exp_o;
    logic [W-1:0]   exp_r;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic n, input logic [W-1:0] d,
                     input logic [7:0] o, input logic [W-1:0] ret);
    vec_t v;
    v.rst = r; v.start = s; v.neg = n; v.instr = d; v.exp_o = o; v.exp_r = ret;
    tbl.push_back(v);
  endtask

  // Reference model: instruction phase 0..4 (fetch..pc update), 5 = paused between instructions.
  typedef enum int {M_IDLE, M_RUN, M_HALT} mmode_t;
  mmode_t       m_mode;
  int           m_phase;
  logic [W-1:0] m_ret;
  logic         m_negq;

  function automatic logic [7:0] model_outs();
    if (m_mode == M_IDLE) return O_IDLE;
    if (m_mode == M_HALT) return O_HALT;
    case (m_phase)
      0:       return O_FETCH;
      1:       return O_DEC;
      2:       return O_READ;
      3:       return O_EXEC;
      4:       return m_negq ? O_PC1 : O_PC0;
      default: return 8'b0000_0010;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE; m_phase = 0; m_ret = '0; m_negq = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (start) begin m_mode = M_RUN; m_phase = 0; end
    end else if (m_mode == M_RUN) begin
      case (m_phase)
        1: if (instr_data == 8'hFF) m_mode = M_HALT; else m_phase = 2;
        3: begin m_negq = neg; m_phase = 4; end
        4: begin
          m_ret = m_ret + 1'b1;
`ifdef RSSB_STEP_EN
          m_phase = 5;
`else
          m_phase = 0;
`endif
        end
        5: if (step) m_phase = 0;
        default: m_phase = m_phase + 1;
      endcase
    end
  endtask

  initial begin
    int pulses;
    int bound;
    bit seen;
    logic [W-1:0] tmp;

    drive(1, 1, 0, 8'h00, 0);
    tick();

`ifndef RSSB_STEP_EN
    add(1, 1, 0, 8'h00, O_IDLE,  0);
    add(1, 1, 0, 8'h00, O_IDLE,  0);
    add(0, 1, 0, 8'h00, O_IDLE,  0);
    add(0, 0, 0, 8'hFF, O_FETCH, 0);   // FF outside DECODE must not halt
    add(0, 0, 0, 8'h10, O_DEC,   0);
    add(0, 0, 0, 8'hFF, O_READ,  0);
    add(0, 0, 0, 8'h00, O_EXEC,  0);
    add(0, 0, 0, 8'h00, O_PC0,   0);
    add(0, 0, 1, 8'h00, O_FETCH, 1);
    add(0, 0, 0, 8'h20, O_DEC,   1);
    add(0, 0, 1, 8'h00, O_READ,  1);   // neg outside EXEC ignored
    add(0, 0, 0, 8'h00, O_EXEC,  1);
    add(0, 0, 1, 8'h00, O_PC0,   1);
    add(0, 0, 0, 8'h00, O_FETCH, 2);
    add(0, 1, 0, 8'h30, O_DEC,   2);
    add(0, 0, 0, 8'h00, O_READ,  2);
    add(0, 0, 1, 8'h00, O_EXEC,  2);
    add(0, 0, 0, 8'h00, O_PC1,   2);
    add(0, 0, 1, 8'h00, O_FETCH, 3);
    add(0, 0, 0, 8'hFF, O_DEC,   3);
    add(0, 1, 0, 8'h00, O_HALT,  3);
    add(0, 1, 0, 8'h00, O_HALT,  3);
    add(1, 1, 0, 8'h00, O_HALT,  3);
    add(0, 0, 0, 8'h00, O_IDLE,  0);
    add(0, 0, 0, 8'h00, O_IDLE,  0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].neg, tbl[i].instr, 0);
      @(negedge clk);
      check_cycle($sformatf("vec%0d", i), tbl[i].exp_o, tbl[i].exp_r);
      $display("vec %0d: rst=%0b start=%0b neg=%0b instr=%h outs=%b retired=%0d",
               i, tbl[i].rst, tbl[i].start, tbl[i].neg, tbl[i].instr, douts(), retired);
      tick();
    end
`endif

    // Reset asserted while in EXEC: no PC write afterwards, retired stays 0.
    drive(1, 0, 0, 8'h00, 0); tick(); tick();
    drive(0, 1, 0, 8'h10, 0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (write_mem) seen = 1; else tick();
    end
    check_val("midrst_reach_exec", {31'd0, seen}, 32'd1);
    rst = 1; start = 0;
    tick();
    rst = 0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (write_pc) seen = 1;
      if (c == 0) check_cycle("midrst_idle", O_IDLE, 0);
      tick();
    end
    check_val("midrst_no_write_pc", {31'd0, seen}, 32'd0);
    $display("seq midrst: retired=%0d", retired);

    // Retired counter wraps after 256 completed instructions.
    drive(1, 0, 0, 8'h00, 1); tick(); tick();
    drive(0, 1, 0, 8'h10, 1);
    pulses = 0;
    bound = 0;
    while (pulses < 256 && bound < 3000) begin
      @(negedge clk);
      if (write_pc) begin
        pulses++;
        tick();
        @(negedge clk);
        if (pulses == 255) check_val("wrap_255", {24'd0, retired}, 32'd255);
        if (pulses == 256) check_val("wrap_0", {24'd0, retired}, 32'd0);
      end else begin
        tick();
      end
      bound++;
    end
    check_val("wrap_done", pulses, 256);
    $display("seq wrap: instructions=%0d retired=%0d", pulses, retired);
    tick();

`ifdef RSSB_STEP_EN
    drive(1, 0, 0, 8'h00, 0); tick();
    drive(0, 1, 0, 8'h10, 0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (write_pc) seen = 1;
      tick();
    end
    check_val("step_reach_pcupd", {31'd0, seen}, 32'd1);
    start = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_cycle($sformatf("pause%0d", c), 8'b0000_0010, 1);
      tick();
    end
    step = 1; tick(); step = 0;
    @(negedge clk); check_cycle("step_fetch", O_FETCH, 1); tick();
    @(negedge clk); check_cycle("step_decode", O_DEC, 1); tick();
    @(negedge clk); check_cycle("step_read", O_READ, 1); tick();
    step = 1;
    @(negedge clk); check_cycle("step_exec", O_EXEC, 1); tick();
    step = 0;
    @(negedge clk); check_cycle("step_pcupd", O_PC0, 1); tick();
    @(negedge clk); check_cycle("step_pause_a", 8'b0000_0010, 2); tick();
    @(negedge clk); check_cycle("step_pause_b", 8'b0000_0010, 2); tick();
    $display("seq step: retired=%0d", retired);
`endif

    // Randomized run against the phase model.
    drive(1, 0, 0, 8'h00, 0);
    m_mode = M_IDLE; m_phase = 0; m_ret = '0; m_negq = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      tmp = W'($urandom_range(0, 254));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
            ($urandom_range(0, 19) == 0) ? 8'hFF : tmp, ($urandom_range(0, 3) == 0));
      @(negedge clk);
      check_cycle($sformatf("rand%0d", c), model_outs(), m_ret);
      @(posedge clk);
      model_step();
      #1;
    end
    $display("seq random: model retired=%0d dut retired=%0d", m_ret, retired);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
